// File: rtl/fivesons_pkg.sv
// Shared definitions for the five-in-a-row board scanner.
//   BOARD_N / WIN_LEN  : board side and winning run length
//   cell codes         : CELL_EMPTY, CELL_P1, CELL_P2 (code 11 is reserved and treated as empty)
//   gaming_status codes: GS_NONE, GS_P1, GS_P2, GS_DRAW
//   direction codes    : DIR_E, DIR_S, DIR_SE, DIR_SW
//   CO_TO_OFFSET(x,y)  : bit offset of cell (x,y) inside the packed board vector
package fivesons_pkg;

    localparam int BOARD_N = 16;
    localparam int WIN_LEN = 5;
    localparam int IDX_W   = $clog2(BOARD_N);
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int BOARD_W = 2 * CELLS;
    localparam int OFF_W   = $clog2(BOARD_W);
    localparam int CNT_W   = $clog2(CELLS) + 1;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] GS_NONE = 2'b00;
    localparam logic [1:0] GS_P1   = 2'b01;
    localparam logic [1:0] GS_P2   = 2'b10;
    localparam logic [1:0] GS_DRAW = 2'b11;

    localparam logic [1:0] DIR_E  = 2'b00;
    localparam logic [1:0] DIR_S  = 2'b01;
    localparam logic [1:0] DIR_SE = 2'b10;
    localparam logic [1:0] DIR_SW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    function automatic logic [OFF_W-1:0] CO_TO_OFFSET(input int x, input int y);
        return OFF_W'(x * 2 + y * 2 * BOARD_N);
    endfunction

endpackage

// File: rtl/run5_detect.sv
// Combinational five-in-a-row check at one cell of the board snapshot.
//   snapshot_i : packed board, cell (x,y) at CO_TO_OFFSET(x,y)
//   x_i, y_i   : cell under test
//   win_o      : a run of WIN_LEN starts at (x,y)
//   player_o   : owner of the run (CELL_P1 / CELL_P2), CELL_EMPTY when no win
//   dir_o      : winning direction, priority E > S > SE > SW
module run5_detect
    import fivesons_pkg::*;
(
    input  logic [BOARD_W-1:0] snapshot_i,
    input  logic [IDX_W-1:0]   x_i,
    input  logic [IDX_W-1:0]   y_i,
    output logic               win_o,
    output logic [1:0]         player_o,
    output logic [1:0]         dir_o
);

    function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] b, input int cx, input int cy);
        return b[CO_TO_OFFSET(cx, cy) +: 2];
    endfunction

    logic [1:0] p;
    logic       legal;
    logic       run_ok;
    int         dx;
    int         dy;
    int         xi;
    int         yi;

    always_comb begin
        win_o    = 1'b0;
        player_o = CELL_EMPTY;
        dir_o    = DIR_E;
        legal    = 1'b0;
        run_ok   = 1'b0;
        dx       = 0;
        dy       = 0;
        xi       = int'(x_i);
        yi       = int'(y_i);
        p        = cell_at(snapshot_i, xi, yi);
        if (p == CELL_P1 || p == CELL_P2) begin
            // Directions visited in priority order; the first legal full run wins.
            for (int d = 0; d < 4; d++) begin
                case (d)
                    0: begin dx = 1;  dy = 0; legal = (xi <= BOARD_N - WIN_LEN); end
                    1: begin dx = 0;  dy = 1; legal = (yi <= BOARD_N - WIN_LEN); end
                    2: begin dx = 1;  dy = 1; legal = (xi <= BOARD_N - WIN_LEN) && (yi <= BOARD_N - WIN_LEN); end
                    default: begin
                        dx = -1; dy = 1;
                        legal = (xi >= WIN_LEN - 1) && (yi <= BOARD_N - WIN_LEN);
                    end
                endcase
                // The bound guard keeps every probed cell on the board, so runs never wrap.
                if (legal && !win_o) begin
                    run_ok = 1'b1;
                    for (int k = 1; k < WIN_LEN; k++) begin
                        if (cell_at(snapshot_i, xi + dx * k, yi + dy * k) != p) begin
                            run_ok = 1'b0;
                        end
                    end
                    if (run_ok) begin
                        win_o    = 1'b1;
                        player_o = p;
                        dir_o    = 2'(d);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/board_win_scanner.sv
// Snapshots the game board on a start pulse, scans it one cell per clock in row-major
// order and reports the first five-in-a-row (or a draw when the board is full).
//   Clck, Reset     : clock, asynchronous active-high reset
//   start           : one-cycle request, accepted only while idle
//   board           : live board, cell (x,y) at board[x*2 + y*32 +: 2]
//   busy            : scan in progress
//   done            : one-cycle pulse, result outputs valid from this cycle on
//   gaming_status   : 00 none, 01 P1 wins, 10 P2 wins, 11 draw
//   win_x/y/dir     : start cell and direction of the winning run, 0 when no win
//   dbg_state       : current FSM state (scan_state_t encoding)
// Handshake: start is a plain pulse with no ready; it is acted on only when the scanner is
// idle (busy==0 and done==0) and otherwise dropped. done carries no back-pressure.
module board_win_scanner
    import fivesons_pkg::*;
(
    input  logic               Clck,
    input  logic               Reset,
    input  logic               start,
    input  logic [BOARD_W-1:0] board,
    output logic               busy,
    output logic               done,
    output logic [1:0]         gaming_status,
    output logic [IDX_W-1:0]   win_x,
    output logic [IDX_W-1:0]   win_y,
    output logic [1:0]         win_dir,
    output logic [1:0]         dbg_state
);

    scan_state_t              state_q, state_d;
    logic [2*IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]         occ_q, occ_d;
    logic [BOARD_W-1:0]       snap_q, snap_d;
    logic [1:0]               status_q, status_d;
    logic [IDX_W-1:0]         wx_q, wx_d;
    logic [IDX_W-1:0]         wy_q, wy_d;
    logic [1:0]               wdir_q, wdir_d;

    logic [IDX_W-1:0]         cell_x;
    logic [IDX_W-1:0]         cell_y;
    logic [1:0]               cur_cell;
    logic                     cell_occ;
    logic [CNT_W-1:0]         occ_next;
    logic                     det_win;
    logic [1:0]               det_player;
    logic [1:0]               det_dir;

    assign cell_x   = idx_q[IDX_W-1:0];
    assign cell_y   = idx_q[2*IDX_W-1:IDX_W];
    assign cur_cell = snap_q[CO_TO_OFFSET(int'(cell_x), int'(cell_y)) +: 2];
    // Reserved code 11 counts as empty.
    assign cell_occ = (cur_cell == CELL_P1) || (cur_cell == CELL_P2);
    assign occ_next = occ_q + CNT_W'(cell_occ);

    run5_detect u_detect (
        .snapshot_i (snap_q),
        .x_i        (cell_x),
        .y_i        (cell_y),
        .win_o      (det_win),
        .player_o   (det_player),
        .dir_o      (det_dir)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        occ_d    = occ_q;
        snap_d   = snap_q;
        status_d = status_q;
        wx_d     = wx_q;
        wy_d     = wy_q;
        wdir_d   = wdir_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    snap_d   = board;
                    idx_d    = '0;
                    occ_d    = '0;
                    status_d = GS_NONE;
                    wx_d     = '0;
                    wy_d     = '0;
                    wdir_d   = DIR_E;
                end
            end
            ST_SCAN: begin
                idx_d = idx_q + 1'b1;
                occ_d = occ_next;
                if (det_win) begin
                    state_d  = ST_DONE;
                    status_d = det_player;
                    wx_d     = cell_x;
                    wy_d     = cell_y;
                    wdir_d   = det_dir;
                end else if (idx_q == '1) begin
                    // occ_next includes the last cell, so a full board reads CELLS here.
                    state_d  = ST_DONE;
                    status_d = (occ_next == CNT_W'(CELLS)) ? GS_DRAW : GS_NONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            occ_q    <= '0;
            snap_q   <= '0;
            status_q <= GS_NONE;
            wx_q     <= '0;
            wy_q     <= '0;
            wdir_q   <= DIR_E;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            occ_q    <= occ_d;
            snap_q   <= snap_d;
            status_q <= status_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            wdir_q   <= wdir_d;
        end
    end

    assign busy          = (state_q == ST_SCAN);
    assign done          = (state_q == ST_DONE);
    assign gaming_status = status_q;
    assign win_x         = wx_q;
    assign win_y         = wy_q;
    assign win_dir       = wdir_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_board_win_scanner.sv
module tb_board_win_scanner;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [511:0] board = '0;
    logic         busy, done;
    logic [1:0]   gaming_status, win_dir, dbg_state;
    logic [3:0]   win_x, win_y;

    always #5 clk = ~clk;

    board_win_scanner dut (
        .Clck          (clk),
        .Reset         (rst),
        .start         (start),
        .board         (board),
        .busy          (busy),
        .done          (done),
        .gaming_status (gaming_status),
        .win_x         (win_x),
        .win_y         (win_y),
        .win_dir       (win_dir),
        .dbg_state     (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Result of scanning a whole board: outcome plus number of edges from start to done.
    typedef struct packed {
        logic [1:0] status;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] dir;
        logic [8:0] edges;
    } res_t;

    function automatic res_t model_eval(input logic [511:0] b);
        int   c[16][16];
        int   occ;
        int   dxs[4];
        int   dys[4];
        res_t r;
        dxs = '{1, 0, 1, -1};
        dys = '{0, 1, 1, 1};
        occ = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                c[x][y] = int'(b[x*2 + y*32 +: 2]);
                if (c[x][y] == 1 || c[x][y] == 2) occ++;
            end
        for (int i = 0; i < 256; i++) begin
            int x, y, p;
            x = i % 16;
            y = i / 16;
            p = c[x][y];
            if (p == 1 || p == 2) begin
                for (int d = 0; d < 4; d++) begin
                    int ex, ey;
                    bit ok;
                    ex = x + 4 * dxs[d];
                    ey = y + 4 * dys[d];
                    if (ex >= 0 && ex < 16 && ey >= 0 && ey < 16) begin
                        ok = 1'b1;
                        for (int k = 1; k < 5; k++)
                            if (c[x + k*dxs[d]][y + k*dys[d]] != p) ok = 1'b0;
                        if (ok) begin
                            r.status = 2'(p);
                            r.x      = 4'(x);
                            r.y      = 4'(y);
                            r.dir    = 2'(d);
                            r.edges  = 9'(i + 1);
                            return r;
                        end
                    end
                end
            end
        end
        r.status = (occ == 256) ? 2'b11 : 2'b00;
        r.x      = '0;
        r.y      = '0;
        r.dir    = '0;
        r.edges  = 9'd256;
        return r;
    endfunction

    res_t start_res;
    always_comb start_res = model_eval(board);

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic        m_busy, m_done;
    logic [11:0] m_out;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_out  <= '0;
            m_left <= 0;
            exp_q.delete();
        end else begin
            m_done <= 1'b0;
            if (!m_busy && !m_done && start) begin
                exp_q.push_back({start_res.status, start_res.x, start_res.y, start_res.dir});
                m_left <= int'(start_res.edges) - 1;
                m_busy <= 1'b1;
                m_out  <= '0;
            end else if (m_busy) begin
                if (m_left == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_out  <= exp_q.pop_front();
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cycle", {16'd0, busy, done, gaming_status, win_x, win_y, win_dir},
                     {16'd0, m_busy, m_done, m_out});
    end

    // ---------------- driver tasks ----------------
    logic [511:0] tb_b;

    task automatic set_cell(input int x, input int y, input logic [1:0] v);
        tb_b[x*2 + y*32 +: 2] = v;
    endtask

    task automatic start_scan(input logic [511:0] b);
        @(negedge clk);
        board = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns edges elapsed since the start edge; 300 means no done was seen.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
    endtask

    task automatic run_case(input string name, input logic [511:0] b, input int exp_edges,
                            input logic [1:0] st, input logic [3:0] x, input logic [3:0] y,
                            input logic [1:0] d);
        res_t r;
        int   n;
        r = model_eval(b);
        chk({name, "_model"}, {11'd0, r.status, r.x, r.y, r.dir, r.edges},
                              {11'd0, st, x, y, d, 9'(exp_edges)});
        start_scan(b);
        wait_done(n);
        chk({name, "_latency"}, 32'(n), 32'(exp_edges));
        chk({name, "_result"}, {20'd0, gaming_status, win_x, win_y, win_dir}, {20'd0, st, x, y, d});
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_outputs", {16'd0, busy, done, gaming_status, win_x, win_y, win_dir}, 32'd0);

        // 1: horizontal P1 run on row 7
        tb_b = '0;
        for (int x = 3; x <= 7; x++) set_cell(x, 7, 2'b01);
        run_case("t1_row", tb_b, 116, 2'b01, 4'd3, 4'd7, 2'b00);

        // 2: anti-diagonal P2 run from (4,0)
        tb_b = '0;
        for (int k = 0; k < 5; k++) set_cell(4 - k, k, 2'b10);
        run_case("t2_sw", tb_b, 5, 2'b10, 4'd4, 4'd0, 2'b11);

        // 3: run that would only exist by wrapping across rows
        tb_b = '0;
        for (int x = 12; x <= 15; x++) set_cell(x, 3, 2'b01);
        set_cell(0, 4, 2'b01);
        run_case("t3_nowrap", tb_b, 256, 2'b00, 4'd0, 4'd0, 2'b00);

        // 4: full board without any run longer than 2
        tb_b = '0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                set_cell(x, y, ((((x >> 1) + y) % 2) == 0) ? 2'b01 : 2'b10);
        run_case("t4_draw", tb_b, 256, 2'b11, 4'd0, 4'd0, 2'b00);

        // 5: six-long run at the first cell, E reported
        tb_b = '0;
        for (int x = 0; x <= 5; x++) set_cell(x, 0, 2'b01);
        for (int x = 0; x <= 4; x++) set_cell(x, 1, 2'b01);
        run_case("t5_prio", tb_b, 1, 2'b01, 4'd0, 4'd0, 2'b00);

        // 6a: extra start and board change mid-scan are ignored
        begin
            int n;
            logic [511:0] win_b;
            win_b = '0;
            for (int x = 3; x <= 7; x++) win_b[x*2 + 7*32 +: 2] = 2'b01;
            start_scan('0);
            repeat (49) @(negedge clk);
            board = win_b;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done(n);
            chk("t6_ignore_latency", 32'(50 + n), 32'd256);
            chk("t6_ignore_result", {20'd0, gaming_status, win_x, win_y, win_dir}, 32'd0);

            // 6b: reset mid-scan aborts with no done pulse
            start_scan('0);
            repeat (99) @(negedge clk);
            chk("t6_busy_before_reset", {31'd0, busy}, 32'd1);
            #2 rst = 1'b1;
            #1 chk("t6_reset_outputs", {16'd0, busy, done, gaming_status, win_x, win_y, win_dir}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            wait_done(n);
            chk("t6_no_done", 32'(n), 32'd300);
        end

        // Randomised boards checked against the model
        for (int it = 0; it < 16; it++) begin
            int dens, n;
            res_t r;
            tb_b = '0;
            dens = $urandom_range(0, 3);
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    if ($urandom_range(0, 9) < dens * 3)
                        set_cell(x, y, 2'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 1) begin
                int sx, sy, d, len, dx, dy;
                logic [1:0] pl;
                sx  = $urandom_range(0, 15);
                sy  = $urandom_range(0, 15);
                d   = $urandom_range(0, 3);
                len = $urandom_range(4, 6);
                pl  = 2'($urandom_range(1, 2));
                dx  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                dy  = (d == 0) ? 0 : 1;
                for (int k = 0; k < len; k++) begin
                    int cx, cy;
                    cx = sx + k * dx;
                    cy = sy + k * dy;
                    if (cx >= 0 && cx < 16 && cy < 16) set_cell(cx, cy, pl);
                end
            end
            r = model_eval(tb_b);
            start_scan(tb_b);
            wait_done(n);
            chk("rand_latency", 32'(n), 32'(r.edges));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
